// File: rtl/tt_check_pkg.sv
// Shared types for the truth-table checker and its gate reference model.
package tt_check_pkg;

  typedef enum logic [2:0] {
    G_AND  = 3'd0,
    G_OR   = 3'd1,
    G_NAND = 3'd2,
    G_NOR  = 3'd3,
    G_XOR  = 3'd4,
    G_XNOR = 3'd5
  } gate_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int SWEEP_LEN = 4;

endpackage

// File: rtl/gate_model.sv
// Combinational reference for the 2-input gates; flags unused selector codes.
module gate_model
  import tt_check_pkg::*;
(
  input  logic [2:0] gate_sel,
  input  logic       a,
  input  logic       b,
  output logic       expected,
  output logic       illegal
);

  always_comb begin
    expected = 1'b0;
    illegal  = 1'b0;
    case (gate_sel)
      G_AND:   expected = a & b;
      G_OR:    expected = a | b;
      G_NAND:  expected = ~(a & b);
      G_NOR:   expected = ~(a | b);
      G_XOR:   expected = a ^ b;
      G_XNOR:  expected = ~(a ^ b);
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/truth_table_checker.sv
// Checks observed gate samples against a selected truth table.
// Optional TT_CHECK_ORDER_EN enforces the 00,01,10,11 sweep order.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int ERR_W       = 8,
  parameter int MAX_SAMPLES = 64,
  parameter int CNT_W       = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_in_a,
  input  logic             s_in_b,
  input  logic             s_out,
  output logic [3:0]       covered,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [2:0]       first_err_vec,
  output logic             done,
  output logic             pass
);

  localparam logic [3:0] FULL = 4'((1 << SWEEP_LEN) - 1);

  state_e           state;
  logic [2:0]       gate_sel_q;
  logic [CNT_W-1:0] cnt;

  logic             expected;
  logic             illegal;
  logic             accept;
  logic [1:0]       idx;
  logic             in_order;
  logic             mismatch;
  logic [3:0]       cov_next;
  logic [ERR_W-1:0] err_next;
  logic [CNT_W-1:0] cnt_next;
  logic             cov_full;
  logic             hit_max;

  gate_model u_model (
    .gate_sel (gate_sel_q),
    .a        (s_in_a),
    .b        (s_in_b),
    .expected (expected),
    .illegal  (illegal)
  );

  assign s_ready = (state == S_RUN) && !start;
  assign accept  = s_valid && s_ready;
  assign idx     = {s_in_a, s_in_b};

`ifdef TT_CHECK_ORDER_EN
  logic [1:0] exp_idx;
  assign in_order = (idx == exp_idx);
`else
  assign in_order = 1'b1;
`endif

  always_comb begin
    mismatch = illegal || (s_out != expected) || !in_order;
    cov_next = covered;
    if (in_order) cov_next = covered | (4'b0001 << idx);
    err_next = err_cnt;
    if (mismatch && (err_cnt != '1)) err_next = err_cnt + ERR_W'(1);
    cnt_next = cnt + CNT_W'(1);
    cov_full = (cov_next == FULL);
    hit_max  = (cnt_next == CNT_W'(MAX_SAMPLES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      gate_sel_q      <= '0;
      cnt             <= '0;
      covered         <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else if (start) begin
      state           <= S_RUN;
      gate_sel_q      <= gate_sel;
      cnt             <= '0;
      covered         <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else if (accept) begin
      cnt     <= cnt_next;
      covered <= cov_next;
      err_cnt <= err_next;
      if (mismatch && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_vec   <= {s_in_a, s_in_b, s_out};
      end
      // Coverage completion takes precedence over the sample limit.
      if (cov_full || hit_max) begin
        state <= S_DONE;
        done  <= 1'b1;
        pass  <= cov_full && (err_next == '0) && !illegal;
      end
    end
  end

`ifdef TT_CHECK_ORDER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_idx <= '0;
    end else if (start) begin
      exp_idx <= '0;
    end else if (accept && in_order) begin
      exp_idx <= exp_idx + 2'd1;
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed self-checking bench for truth_table_checker.
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] gate_sel = 3'd0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       s_in_a = 1'b0;
  logic       s_in_b = 1'b0;
  logic       s_out = 1'b0;
  logic [3:0] covered;
  logic [7:0] err_cnt;
  logic       first_err_valid;
  logic [2:0] first_err_vec;
  logic       done;
  logic       pass;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  truth_table_checker #(
    .ERR_W       (8),
    .MAX_SAMPLES (400),
    .CNT_W       (9)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .gate_sel        (gate_sel),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_in_a          (s_in_a),
    .s_in_b          (s_in_b),
    .s_out           (s_out),
    .covered         (covered),
    .err_cnt         (err_cnt),
    .first_err_valid (first_err_valid),
    .first_err_vec   (first_err_vec),
    .done            (done),
    .pass            (pass)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [2:0] sel);
    @(negedge clk);
    start    = 1'b1;
    gate_sel = sel;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic push(input logic [2:0] v);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    {s_in_a, s_in_b, s_out} = v;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] cov,
                            input logic [7:0] err, input logic fev,
                            input logic [2:0] vec, input logic dn,
                            input logic ps);
    @(negedge clk);
    check({tag, "_cov"},  32'(covered), 32'(cov));
    check({tag, "_err"},  32'(err_cnt), 32'(err));
    check({tag, "_fev"},  32'(first_err_valid), 32'(fev));
    check({tag, "_vec"},  32'(first_err_vec), 32'(vec));
    check({tag, "_done"}, 32'(done), 32'(dn));
    check({tag, "_pass"}, 32'(pass), 32'(ps));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_outs("reset", 4'h0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("reset_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;

    // Samples in IDLE are ignored
    @(negedge clk);
    s_valid = 1'b1;
    {s_in_a, s_in_b, s_out} = 3'b011;
    repeat (2) @(negedge clk);
    s_valid = 1'b0;
    check_outs("idle", 4'h0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0);

    // AND, full clean sweep
    do_start(3'd0);
    push(3'b000); push(3'b010); push(3'b100);
    check("and_not_done", 32'(done), 32'd0);
    push(3'b111);
    check_outs("and", 4'hF, 8'd0, 1'b0, 3'd0, 1'b1, 1'b1);
    check("and_ready", 32'(s_ready), 32'd0);
    repeat (3) @(negedge clk);
    check_outs("and_hold", 4'hF, 8'd0, 1'b0, 3'd0, 1'b1, 1'b1);

    // XOR, single mismatch on the last vector
    do_start(3'd4);
    check("restart_done", 32'(done), 32'd0);
    check("restart_cov", 32'(covered), 32'd0);
    push(3'b000); push(3'b011); push(3'b101); push(3'b111);
    check_outs("xor", 4'hF, 8'd1, 1'b1, 3'b111, 1'b1, 1'b0);

    // XOR, first mismatch kept over the second
    do_start(3'd4);
    push(3'b001); push(3'b010); push(3'b101); push(3'b110);
    check_outs("xor2", 4'hF, 8'd2, 1'b1, 3'b001, 1'b1, 1'b0);

    // OR, partial coverage until the sample limit
    do_start(3'd1);
    for (int i = 0; i < 399; i++) push((i % 2 == 0) ? 3'b000 : 3'b011);
    check("or_pre_done", 32'(done), 32'd0);
    push(3'b011);
    check_outs("or_tmo", 4'b0011, 8'd0, 1'b0, 3'd0, 1'b1, 1'b0);

    // AND, coverage completes on exactly the final allowed sample
    do_start(3'd0);
    for (int i = 0; i < 397; i++) push(3'b000);
    push(3'b010); push(3'b100); push(3'b111);
    check_outs("cov_wins", 4'hF, 8'd0, 1'b0, 3'd0, 1'b1, 1'b1);

    // AND, 300 mismatches saturate the counter
    do_start(3'd0);
    for (int i = 0; i < 300; i++) push(3'b001);
    check_outs("sat", 4'b0001, 8'd255, 1'b1, 3'b001, 1'b0, 1'b0);

    // Illegal selector, otherwise-correct AND data
    do_start(3'd6);
    push(3'b000); push(3'b010); push(3'b100); push(3'b111);
    check_outs("illegal", 4'hF, 8'd4, 1'b1, 3'b000, 1'b1, 1'b0);

    // Reset mid-run
    do_start(3'd1);
    push(3'b000); push(3'b011);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_ready", 32'(s_ready), 32'd0);
    check_outs("mrst", 4'h0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Start together with a valid sample: not accepted
    @(negedge clk);
    start    = 1'b1;
    gate_sel = 3'd1;
    s_valid  = 1'b1;
    {s_in_a, s_in_b, s_out} = 3'b011;
    #1 check("start_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    start   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("start_cov", 32'(covered), 32'd0);
    check("start_run", 32'(s_ready), 32'd1);

`ifdef TT_CHECK_ORDER_EN
    do_start(3'd2);
    push(3'b001); push(3'b101);
    check_outs("order", 4'b0001, 8'd1, 1'b1, 3'b101, 1'b0, 1'b0);
`else
    do_start(3'd2);
    push(3'b001); push(3'b101);
    check_outs("noorder", 4'b0101, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
